bird_physics: RTL and testbench
===============================

// Module: bird_physics
// PURPOSE
//  Parametrised vertical-motion integrator for a player sprite in the game pipeline.
//  Holds for a start delay, then integrates gravity and flap impulses once per gameClk.
//  Clamps the sprite at the ceiling and floor and reports collision pulses.
//  Position and velocity feed the renderer; hit pulses feed game-state logic.
// PARAMETERS
//  Y_W            11     signed width of y_out / v_out
//  SCREEN_HEIGHT  480    playfield height, pixels
//  BIRD_HEIGHT    16     sprite height; floor Y_MIN=BIRD_HEIGHT, ceiling Y_MAX=SCREEN_HEIGHT-BIRD_HEIGHT
//  Y_INIT         240    reset position
//  MAX_VELOCITY   64     downward velocity saturation magnitude
//  FLAP_VELOCITY  64     velocity loaded on an accepted flap
//  ACCEL          1      gravity subtracted per update
//  VEL_FRAC       4      velocity fraction bits; displacement = v_out / 2**VEL_FRAC
//  DELAY          20000  gameClk cycles held after reset (counter width $clog2(DELAY+1))
//  FLAP_COOLDOWN  8      cycles after an accepted flap during which flaps are ignored
// PORTS
//  gameClk      in   1    game clock
//  reset_n      in   1    asynchronous, active-low reset
//  button       in   1    flap request, level, synchronous to gameClk
//  finished     in   1    freeze: all state holds while high
//  y_out        out  Y_W  signed position, up positive
//  v_out        out  Y_W  signed velocity, fixed point, VEL_FRAC fraction bits
//  flap_pulse   out  1    1-cycle pulse, flap accepted
//  hit_ceiling  out  1    1-cycle pulse, ceiling clamp applied
//  hit_floor    out  1    1-cycle pulse, floor clamp applied
//  grounded     out  1    high while in GROUNDED
// BEHAVIOUR
//  Reset (reset_n=0, async): y_out=Y_INIT, v_out=0, pulses=0, grounded=0, state=HOLD,
//    delay counter=DELAY, cooldown=0. Reset mid-flight takes effect immediately.
//  finished=1: every register holds, including delay and cooldown counters; no pulses.
//    reset_n wins over finished.
//  FSM: HOLD -> FLY when the delay counter is 0. The counter decrements by 1 per cycle.
//    FLY -> GROUNDED on floor clamp. GROUNDED -> FLY on an accepted flap.
//  flap_acc = flap request && cooldown==0. Acceptance loads cooldown=FLAP_COOLDOWN.
//    Cooldown decrements to 0 in FLY and GROUNDED. Flaps in HOLD are discarded.
//  FLY update, registered, 1-cycle latency; all comparisons signed:
//    ny = y_out + v_out/2**VEL_FRAC (signed divide, truncate toward zero)
//    ny > Y_MAX: y<=Y_MAX, v<=0, hit_ceiling=1. Ceiling priority over flap; the flap is
//      still consumed and flap_pulse fires.
//    ny < Y_MIN: y<=Y_MIN, v<=0, hit_floor=1, ->GROUNDED. A flap in the same cycle is
//      consumed, but FSM stays GROUNDED.
//    else: y<=ny; v<= flap_acc ? FLAP_VELOCITY : max(v_out-ACCEL, -MAX_VELOCITY).
//  GROUNDED: y=Y_MIN, v=0. On flap_acc: v<=FLAP_VELOCITY, ->FLY, flap_pulse=1.
//  Intermediate sums use Y_W+1 bits; no wrap is permitted.
// CONFIGURATION
//  BIRD_FLAP_EDGE_EN defined: flap request = rising edge of button (button & ~button_q).
//    Holding button yields one flap.
//  BIRD_FLAP_EDGE_EN undefined: flap request = button level (legacy).
//    Held button re-flaps every FLAP_COOLDOWN+1 cycles.
// STRUCTURE
//  Shared constants.v: SCREEN_HEIGHT, BIRD_HEIGHT, Y_INIT, MAX_VELOCITY, ACCEL, DELAY defaults.
//  Shared constants.v: FSM state encodings ST_HOLD / ST_FLY / ST_GROUNDED.
//  Sub-module bird_flap_gate: button edge/level select, cooldown counter, outputs flap_acc.
// TESTING
//  1 reset_n=0 then 1, DELAY=10 -> y=240, v=0 for 10 cycles, then v=-1,-2,...
//  2 free fall from y=240, v=0 -> v saturates at -64 after 64 updates; y unchanged until v<=-16.
//  3 edge-mode button held 20 cycles from FLY -> one flap_pulse, v=64.
//    Second edge 5 cycles later is ignored; edge at cooldown 0 is accepted.
//  4 y=460, v=64 -> ny=464 accepted; next update clamps y=464, v=0, hit_ceiling 1 cycle.
//  5 y=18, v=-64 -> y=16, v=0, hit_floor pulse, grounded=1; flap -> v=64, grounded=0.
//  6 finished=1 for 50 cycles mid-flight -> y/v/counters frozen, then resume.
//    reset_n pulsed low mid-flight -> async return to reset values.

Source files
------------

// File: rtl/bird_physics_pkg.sv
// Shared defaults and FSM state encodings for the bird vertical-motion integrator.
// Latency: n/a (constants only). Backpressure: n/a.
package bird_physics_pkg;

  localparam int DEF_Y_W           = 11;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_BIRD_HEIGHT   = 16;
  localparam int DEF_Y_INIT        = 240;
  localparam int DEF_MAX_VELOCITY  = 64;
  localparam int DEF_FLAP_VELOCITY = 64;
  localparam int DEF_ACCEL         = 1;
  localparam int DEF_VEL_FRAC      = 4;
  localparam int DEF_DELAY         = 20000;
  localparam int DEF_FLAP_COOLDOWN = 8;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_FLY      = 2'd1,
    ST_GROUNDED = 2'd2
  } bird_state_t;

endpackage

// File: rtl/bird_flap_gate.sv
// Flap request qualification: button edge/level select plus post-flap cooldown; BIRD_FLAP_EDGE_EN selects edge mode.
// Latency: flap_acc is combinational from button and registered cooldown.
// Backpressure: none; requests arriving while disabled or cooling down are dropped.
module bird_flap_gate
  import bird_physics_pkg::*;
#(
  parameter int FLAP_COOLDOWN = DEF_FLAP_COOLDOWN
) (
  input  logic gameClk,
  input  logic reset_n,
  input  logic button,
  input  logic finished,
  input  logic enable,
  output logic flap_acc
);

  localparam int CD_W = (FLAP_COOLDOWN > 0) ? $clog2(FLAP_COOLDOWN + 1) : 1;

  logic            flap_req;
  logic [CD_W-1:0] cooldown;

`ifdef BIRD_FLAP_EDGE_EN
  logic button_q;

  always_ff @(posedge gameClk or negedge reset_n) begin
    if (!reset_n)       button_q <= 1'b0;
    else if (!finished) button_q <= button;
  end

  assign flap_req = button & ~button_q;
`else
  assign flap_req = button;
`endif

  assign flap_acc = enable & flap_req & (cooldown == '0);

  // Cooldown only runs once flight has started; HOLD leaves it parked at zero.
  always_ff @(posedge gameClk or negedge reset_n) begin
    if (!reset_n) begin
      cooldown <= '0;
    end else if (!finished) begin
      if (flap_acc)                      cooldown <= CD_W'(FLAP_COOLDOWN);
      else if (enable && cooldown != '0) cooldown <= cooldown - CD_W'(1);
    end
  end

endmodule

// File: rtl/bird_physics.sv
// Vertical-motion integrator for the player sprite: start delay, gravity, flap impulse, ceiling/floor clamps.
// Latency: one gameClk per update, all outputs registered except grounded (decoded from state).
// Backpressure: finished freezes all state and suppresses pulses; flap mode set by BIRD_FLAP_EDGE_EN.
module bird_physics
  import bird_physics_pkg::*;
#(
  parameter int Y_W           = DEF_Y_W,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int BIRD_HEIGHT   = DEF_BIRD_HEIGHT,
  parameter int Y_INIT        = DEF_Y_INIT,
  parameter int MAX_VELOCITY  = DEF_MAX_VELOCITY,
  parameter int FLAP_VELOCITY = DEF_FLAP_VELOCITY,
  parameter int ACCEL         = DEF_ACCEL,
  parameter int VEL_FRAC      = DEF_VEL_FRAC,
  parameter int DELAY         = DEF_DELAY,
  parameter int FLAP_COOLDOWN = DEF_FLAP_COOLDOWN
) (
  input  logic                  gameClk,
  input  logic                  reset_n,
  input  logic                  button,
  input  logic                  finished,
  output logic signed [Y_W-1:0] y_out,
  output logic signed [Y_W-1:0] v_out,
  output logic                  flap_pulse,
  output logic                  hit_ceiling,
  output logic                  hit_floor,
  output logic                  grounded
);

  localparam int DLY_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  localparam logic signed [Y_W:0] Y_MAX  = (Y_W+1)'(SCREEN_HEIGHT - BIRD_HEIGHT);
  localparam logic signed [Y_W:0] Y_MIN  = (Y_W+1)'(BIRD_HEIGHT);
  localparam logic signed [Y_W:0] V_MIN  = (Y_W+1)'(-MAX_VELOCITY);
  localparam logic signed [Y_W:0] V_DIV  = (Y_W+1)'(1 << VEL_FRAC);
  localparam logic signed [Y_W:0] V_ACC  = (Y_W+1)'(ACCEL);
  localparam logic signed [Y_W:0] V_FLAP = (Y_W+1)'(FLAP_VELOCITY);

  bird_state_t            state, state_n;
  logic [DLY_W-1:0]       dly, dly_n;
  logic signed [Y_W-1:0]  y_n, v_n, v_sat;
  logic signed [Y_W:0]    y_x, v_x, ny, v_dec;
  logic                   fp_n, hc_n, hf_n;
  logic                   flap_acc;

  bird_flap_gate #(
    .FLAP_COOLDOWN (FLAP_COOLDOWN)
  ) u_flap_gate (
    .gameClk  (gameClk),
    .reset_n  (reset_n),
    .button   (button),
    .finished (finished),
    .enable   (state != ST_HOLD),
    .flap_acc (flap_acc)
  );

  assign grounded = (state == ST_GROUNDED);

  // One guard bit keeps the position sum and gravity step from wrapping.
  assign y_x   = y_out;
  assign v_x   = v_out;
  assign ny    = y_x + v_x / V_DIV;
  assign v_dec = v_x - V_ACC;
  assign v_sat = (v_dec < V_MIN) ? V_MIN[Y_W-1:0] : v_dec[Y_W-1:0];

  always_comb begin
    state_n = state;
    dly_n   = dly;
    y_n     = y_out;
    v_n     = v_out;
    fp_n    = 1'b0;
    hc_n    = 1'b0;
    hf_n    = 1'b0;
    case (state)
      ST_HOLD: begin
        if (dly == '0) state_n = ST_FLY;
        else           dly_n   = dly - DLY_W'(1);
      end
      ST_FLY: begin
        fp_n = flap_acc;
        if (ny > Y_MAX) begin
          y_n  = Y_MAX[Y_W-1:0];
          v_n  = '0;
          hc_n = 1'b1;
        end else if (ny < Y_MIN) begin
          y_n     = Y_MIN[Y_W-1:0];
          v_n     = '0;
          hf_n    = 1'b1;
          state_n = ST_GROUNDED;
        end else begin
          y_n = ny[Y_W-1:0];
          v_n = flap_acc ? V_FLAP[Y_W-1:0] : v_sat;
        end
      end
      ST_GROUNDED: begin
        y_n = Y_MIN[Y_W-1:0];
        v_n = '0;
        if (flap_acc) begin
          v_n     = V_FLAP[Y_W-1:0];
          state_n = ST_FLY;
          fp_n    = 1'b1;
        end
      end
      default: state_n = ST_HOLD;
    endcase
  end

  always_ff @(posedge gameClk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_HOLD;
      dly         <= DLY_W'(DELAY);
      y_out       <= Y_W'(Y_INIT);
      v_out       <= '0;
      flap_pulse  <= 1'b0;
      hit_ceiling <= 1'b0;
      hit_floor   <= 1'b0;
    end else if (finished) begin
      flap_pulse  <= 1'b0;
      hit_ceiling <= 1'b0;
      hit_floor   <= 1'b0;
    end else begin
      state       <= state_n;
      dly         <= dly_n;
      y_out       <= y_n;
      v_out       <= v_n;
      flap_pulse  <= fp_n;
      hit_ceiling <= hc_n;
      hit_floor   <= hf_n;
    end
  end

endmodule

// File: tb/tb_bird_physics.sv
// Randomized scoreboard bench for bird_physics against a plain-arithmetic motion model.
// Latency: expectation pushed at negedge, compared 1 time unit after the next posedge.
// Backpressure: finished windows and mid-flight resets are part of the stimulus.
module tb_bird_physics;

  localparam int YW    = 11;
  localparam int SH    = 480;
  localparam int BH    = 16;
  localparam int YI    = 240;
  localparam int MAXV  = 64;
  localparam int FLAPV = 64;
  localparam int ACC   = 1;
  localparam int VF    = 4;
  localparam int DLY   = 10;
  localparam int CD    = 8;
  localparam int YMAX  = SH - BH;
  localparam int YMIN  = BH;
`ifdef BIRD_FLAP_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic gameClk = 1'b0;
  logic reset_n = 1'b0;
  logic button = 1'b0;
  logic finished = 1'b0;
  logic signed [YW-1:0] y_out, v_out;
  logic flap_pulse, hit_ceiling, hit_floor, grounded;

  always #5 gameClk = ~gameClk;

  bird_physics #(
    .Y_W(YW), .SCREEN_HEIGHT(SH), .BIRD_HEIGHT(BH), .Y_INIT(YI),
    .MAX_VELOCITY(MAXV), .FLAP_VELOCITY(FLAPV), .ACCEL(ACC),
    .VEL_FRAC(VF), .DELAY(DLY), .FLAP_COOLDOWN(CD)
  ) dut (
    .gameClk(gameClk), .reset_n(reset_n), .button(button), .finished(finished),
    .y_out(y_out), .v_out(v_out), .flap_pulse(flap_pulse),
    .hit_ceiling(hit_ceiling), .hit_floor(hit_floor), .grounded(grounded)
  );

  typedef struct {
    int y;
    int v;
    bit fp;
    bit hc;
    bit hf;
    bit gr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Model: hold countdown, then Newtonian step with clamps and a flap cooldown.
  int my, mv, mdly, mcd;
  bit mhold, mground, mprev, mfp, mhc, mhf;

  function automatic void model_reset();
    my = YI; mv = 0; mdly = DLY; mcd = 0;
    mhold = 1; mground = 0; mprev = 0;
    mfp = 0; mhc = 0; mhf = 0;
  endfunction

  function automatic void model_step(bit b, bit f);
    bit req, acc;
    int ny;
    mfp = 0; mhc = 0; mhf = 0;
    if (f) return;
    req = EDGE ? (b && !mprev) : b;
    mprev = b;
    if (mhold) begin
      if (mdly == 0) mhold = 0;
      else mdly = mdly - 1;
      return;
    end
    acc = req && (mcd == 0);
    if (acc) mcd = CD;
    else if (mcd > 0) mcd = mcd - 1;
    mfp = acc;
    if (mground) begin
      if (acc) begin
        mv = FLAPV;
        mground = 0;
      end
    end else begin
      ny = my + mv / (2 ** VF);
      if (ny > YMAX) begin
        my = YMAX; mv = 0; mhc = 1;
      end else if (ny < YMIN) begin
        my = YMIN; mv = 0; mhf = 1; mground = 1;
      end else begin
        my = ny;
        if (acc) mv = FLAPV;
        else mv = (mv - ACC < -MAXV) ? -MAXV : mv - ACC;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, want);
    end
  endtask

  task automatic cycle(input bit b, input bit f, input bit r);
    bit was;
    @(negedge gameClk);
    button = b;
    finished = f;
    if (!r) begin
      was = reset_n;
      reset_n = 1'b0;
      model_reset();
      if (was) begin
        #1;
        chk("async_rst_y", int'(y_out), YI);
        chk("async_rst_v", int'(v_out), 0);
        chk("async_rst_grounded", int'(grounded), 0);
      end
    end else begin
      reset_n = 1'b1;
      model_step(b, f);
    end
    q.push_back('{my, mv, mfp, mhc, mhf, mground});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge gameClk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("y_out", int'(y_out), e.y);
        chk("v_out", int'(v_out), e.v);
        chk("flap_pulse", int'(flap_pulse), int'(e.fp));
        chk("hit_ceiling", int'(hit_ceiling), int'(e.hc));
        chk("hit_floor", int'(hit_floor), int'(e.hf));
        chk("grounded", int'(grounded), int'(e.gr));
      end
    end
  end

  initial begin : driver
    int kind, len;
    bit b, f;
    model_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    repeat (90) cycle(0, 0, 1);
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(40, 200);
      for (int i = 0; i < len; i++) begin
        if (kind == 0)      b = 1'b1;
        else if (kind == 1) b = 1'b0;
        else                b = 1'($urandom_range(0, 1));
        f = ($urandom_range(0, 31) == 0);
        cycle(b, f, 1);
      end
      if (s == 12) begin
        repeat (50) cycle(1'($urandom_range(0, 1)), 1, 1);
      end
      if (s == 25) begin
        cycle(0, 1, 0);
        cycle(1, 0, 0);
      end
    end
    repeat (3) @(posedge gameClk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
